// File: rtl/line_buffer_pkg.sv
// Shared definitions for the line buffer ring.
// Holds the default sizes, the tap limit, a constant clog2 helper, the bank
// index helper and the line event encoding used by the top.
package line_buffer_pkg;

  localparam int TAPS_MAX   = 7;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_LINE_W = 2048;

  // Line-level events decoded once per cycle; frame start wins over end of line.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_EOL   = 2'd1,
    EV_FRAME = 2'd2
  } line_event_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bank holding the line k+1 lines before the one being written to sel,
  // i.e. (sel-1-k) mod nb. Adding nb first keeps the operand non-negative,
  // and since k < nb-1 one conditional subtract is enough.
  function automatic int tap_bank(input int sel, input int k, input int nb);
    int b;
    b = sel + nb - 1 - k;
    if (b >= nb) b = b - nb;
    return b;
  endfunction

endpackage

// File: rtl/line_buffer_ring_dpram.sv
// Single-clock line RAM: one write port, one read port, registered read.
// Ports:
//   clk    clock (rising edge)
//   we     write enable, waddr/wdata write address and data
//   re     read enable, raddr read address
//   rdata  read data, valid the cycle after re (holds when re=0)
module lb_dpram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_ring.sv
// N-tap line buffer for raw Bayer pixel streams.
// Keeps the last TAPS lines in a ring of TAPS+1 line RAMs and presents the
// current pixel together with the same column from each previous line.
// Ports:
//   CCD_PIXCLK   pixel clock, RESET_N async active-low reset
//   iFVAL/iLVAL  frame / line valid levels, iDVAL pixel strobe, iDATA pixel
//   oDATA/oX     current pixel and its column, one cycle after accept
//   oTAPS        [k*DATA_W +: DATA_W] = same column, k+1 lines ago (0 if absent)
//   oDVAL        output strobe, oTAPS_VALID all taps come from this frame
//   oOVERFLOW    sticky line-too-long flag, cleared on frame start
// Handshake: none. oDVAL is a pure strobe with no ready; downstream must
// take one pixel per cycle whenever oDVAL is high.
module line_buffer_ring
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int TAPS   = 2,
  localparam int X_W   = clog2(LINE_W)
) (
  input  logic                   CCD_PIXCLK,
  input  logic                   RESET_N,
  input  logic                   iFVAL,
  input  logic                   iLVAL,
  input  logic                   iDVAL,
  input  logic [DATA_W-1:0]      iDATA,
  output logic [DATA_W-1:0]      oDATA,
  output logic [TAPS*DATA_W-1:0] oTAPS,
  output logic [X_W-1:0]         oX,
  output logic                   oDVAL,
  output logic                   oTAPS_VALID,
  output logic                   oOVERFLOW
);

  localparam int NB    = TAPS + 1;
  localparam int SEL_W = clog2(NB);
  localparam int LF_W  = 3;
  localparam int XC_W  = X_W + 1;  // column counter must reach LINE_W itself

  localparam logic [XC_W-1:0]  X_LIM    = XC_W'(LINE_W);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NB - 1);
  localparam logic [LF_W-1:0]  LF_FULL  = LF_W'(TAPS);

  logic              fval_d, lval_d, armed;
  logic [XC_W-1:0]   x;
  logic [SEL_W-1:0]  wr_sel, sel_q;
  logic [LF_W-1:0]   lines_filled;
  logic [XC_W-1:0]   len [NB];
  logic [TAPS-1:0]   mask_q;
  logic [DATA_W-1:0] rd_q [NB];

  logic              fval_rise, lval_rise, accept, wr_ok, ovf_hit, eol;
  logic [XC_W-1:0]   x_cur;
  logic [SEL_W-1:0]  sel_cur;
  logic [TAPS-1:0]   mask_nxt;
  line_event_e       ev;

  // A pixel may arrive in the very cycle LVAL rises, so the column is
  // cleared combinationally for that cycle as well as in the register.
  always_comb begin
    fval_rise = iFVAL & ~fval_d;
    lval_rise = iLVAL & ~lval_d;
    accept    = (armed | lval_rise) & iFVAL & iLVAL & iDVAL;
    x_cur     = lval_rise ? '0 : x;
    wr_ok     = accept & (x_cur < X_LIM);
    ovf_hit   = accept & ~(x_cur < X_LIM);
    sel_cur   = fval_rise ? '0 : wr_sel;
    // Normal LVAL fall inside the frame, or FVAL dropping under a live line.
    eol       = armed & ((lval_d & ~iLVAL & iFVAL) | (fval_d & ~iFVAL & lval_d));
    ev        = fval_rise ? EV_FRAME : (eol ? EV_EOL : EV_NONE);
  end

  // A tap is only shown if its bank's stored line reaches this column; on a
  // frame start all lengths are about to clear, so nothing is shown.
  always_comb begin
    mask_nxt = '0;
    for (int k = 0; k < TAPS; k++) begin
      mask_nxt[k] = ~fval_rise &
                    (x_cur < len[SEL_W'(tap_bank(int'(sel_cur), k, NB))]);
    end
  end

  always_ff @(posedge CCD_PIXCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fval_d       <= 1'b0;
      // Treating LVAL as already high means a line in progress at release
      // is not mistaken for a new line; only a genuine rise arms the input.
      lval_d       <= 1'b1;
      armed        <= 1'b0;
      x            <= '0;
      wr_sel       <= '0;
      lines_filled <= '0;
      for (int b = 0; b < NB; b++) len[b] <= '0;
      oOVERFLOW    <= 1'b0;
      oDVAL        <= 1'b0;
      oDATA        <= '0;
      oX           <= '0;
      oTAPS_VALID  <= 1'b0;
      mask_q       <= '0;
      sel_q        <= '0;
    end else begin
      fval_d <= iFVAL;
      lval_d <= iLVAL;
      if (lval_rise) armed <= 1'b1;

      if (wr_ok)          x <= x_cur + 1'b1;
      else if (lval_rise) x <= '0;

      case (ev)
        EV_FRAME: begin
          wr_sel       <= '0;
          lines_filled <= '0;
          for (int b = 0; b < NB; b++) len[b] <= '0;
        end
        EV_EOL: begin
          len[wr_sel]  <= x;
          wr_sel       <= (wr_sel == SEL_LAST) ? '0 : wr_sel + 1'b1;
          lines_filled <= (lines_filled == LF_FULL) ? LF_FULL : lines_filled + 1'b1;
        end
        default: ;
      endcase

      if (fval_rise)    oOVERFLOW <= 1'b0;
      else if (ovf_hit) oOVERFLOW <= 1'b1;

      // Pixels past LINE_W have no RAM slot and no column code, so only
      // stored pixels are emitted.
      oDVAL <= wr_ok;
      if (wr_ok) begin
        oDATA       <= iDATA;
        oX          <= x_cur[X_W-1:0];
        oTAPS_VALID <= ~fval_rise & (lines_filled == LF_FULL);
        mask_q      <= mask_nxt;
        sel_q       <= sel_cur;
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    lb_dpram #(
      .DATA_W(DATA_W),
      .DEPTH (LINE_W),
      .ADDR_W(X_W)
    ) u_ram (
      .clk  (CCD_PIXCLK),
      .we   (wr_ok && (sel_cur == SEL_W'(b))),
      .waddr(x_cur[X_W-1:0]),
      .wdata(iDATA),
      .re   (wr_ok),
      .raddr(x_cur[X_W-1:0]),
      .rdata(rd_q[b])
    );
  end

  // Tap mux after the RAM register; the mask also hides undefined RAM
  // contents after reset.
  always_comb begin
    logic [SEL_W-1:0] tb;
    tb    = '0;
    oTAPS = '0;
    for (int k = 0; k < TAPS; k++) begin
      tb = SEL_W'(tap_bank(int'(sel_q), k, NB));
      if (mask_q[k]) oTAPS[k*DATA_W +: DATA_W] = rd_q[tb];
    end
  end

endmodule

// File: tb/tb_line_buffer_ring.sv
// Bench for line_buffer_ring: TAPS=2, LINE_W=16, DATA_W=12.
module tb_line_buffer_ring;
  import line_buffer_pkg::*;

  localparam int DATA_W = 12;
  localparam int LINE_W = 16;
  localparam int TAPS   = 2;
  localparam int X_W    = clog2(LINE_W);
  localparam int TW     = TAPS * DATA_W;
  localparam int EW     = DATA_W + X_W + TW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              fval = 0, lval = 0, dval = 0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] o_data;
  logic [TW-1:0]     o_taps;
  logic [X_W-1:0]    o_x;
  logic              o_dval, o_tv, o_ovf;

  line_buffer_ring #(.DATA_W(DATA_W), .LINE_W(LINE_W), .TAPS(TAPS)) dut (
    .CCD_PIXCLK (clk),
    .RESET_N    (rst_n),
    .iFVAL      (fval),
    .iLVAL      (lval),
    .iDVAL      (dval),
    .iDATA      (din),
    .oDATA      (o_data),
    .oTAPS      (o_taps),
    .oX         (o_x),
    .oDVAL      (o_dval),
    .oTAPS_VALID(o_tv),
    .oOVERFLOW  (o_ovf)
  );

  // checking
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: history of stored lines of the current frame
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] hist [TAPS][LINE_W];
  int                hlen [TAPS];
  int                nprev = 0;
  logic [DATA_W-1:0] cur [LINE_W];
  int                col = 0;
  bit                armed_m = 0, fp = 0, lp = 1;
  bit                pending = 0, ovf_m = 0;

  task automatic do_cycle(input bit f, input bit l, input bit d, input logic [DATA_W-1:0] dat);
    bit fr, lr, acc, eol, pend_n, ovf_n;
    logic [TW-1:0] et;
    fval = f; lval = l; dval = d; din = dat;
    fr = f & ~fp;
    lr = l & ~lp;
    pend_n = 0;
    ovf_n  = ovf_m;
    if (fr) begin
      nprev = 0;
      ovf_n = 0;
    end
    if (lr) begin
      armed_m = 1;
      col = 0;
    end
    acc = armed_m & f & l & d;
    if (acc) begin
      if (col < LINE_W) begin
        et = '0;
        for (int k = 0; k < TAPS; k++)
          if (k < nprev && col < hlen[k]) et[k*DATA_W +: DATA_W] = hist[k][col];
        exp_q.push_back({dat, X_W'(col), et, 1'(nprev >= TAPS)});
        cur[col] = dat;
        col++;
        pend_n = 1;
      end else begin
        ovf_n = 1;
      end
    end
    eol = ~fr & armed_m & ((lp & ~l & f) | (fp & ~f & lp));
    if (eol) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        hist[k] = hist[k-1];
        hlen[k] = hlen[k-1];
      end
      hist[0] = cur;
      hlen[0] = col;
      if (nprev < TAPS) nprev++;
    end
    fp = f;
    lp = l;
    @(posedge clk);
    #1;
    pending = pend_n;
    ovf_m   = ovf_n;
  endtask

  task automatic frame_start();
    do_cycle(0, 0, 0, '0);
    do_cycle(0, 0, 0, '0);
    do_cycle(1, 0, 0, '0);
  endtask

  task automatic send_line(input int line, input int n);
    do_cycle(1, 1, 0, '0);
    for (int c = 0; c < n; c++) begin
      while ($urandom_range(0, 3) == 0) do_cycle(1, 1, 0, DATA_W'($urandom_range(0, 4095)));
      do_cycle(1, 1, 1, DATA_W'(line * 16 + c));
    end
    do_cycle(1, 0, 0, '0);
    do_cycle(1, 0, 0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_taps"}, 64'(o_taps), 64'd0);
    chk({tag, "_x"},    64'(o_x),    64'd0);
    chk({tag, "_dval"}, 64'(o_dval), 64'd0);
    chk({tag, "_tv"},   64'(o_tv),   64'd0);
    chk({tag, "_ovf"},  64'(o_ovf),  64'd0);
  endtask

  // Async reset in the middle of a cycle; the line in flight is discarded.
  task automatic mid_reset();
    rst_n = 0;
    pending = 0;
    ovf_m = 0;
    exp_q.delete();
    nprev = 0;
    armed_m = 0;
    fp = 0;
    lp = 1;
    #2;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // scoreboard monitor, samples on the falling edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      chk("dval", 64'(o_dval), 64'(pending));
      chk("ovf",  64'(o_ovf),  64'(ovf_m));
      if (o_dval) begin
        if (exp_q.size() == 0) begin
          chk("spurious", 64'(o_dval), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data", 64'(o_data), 64'(e[TW+X_W+1 +: DATA_W]));
          chk("x",    64'(o_x),    64'(e[TW+1 +: X_W]));
          chk("taps", 64'(o_taps), 64'(e[1 +: TW]));
          chk("tv",   64'(o_tv),   64'(e[0]));
        end
      end
    end
  end

  // main sequence
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    do_cycle(0, 0, 0, '0);

    // five lines of 8: first-line masking, full taps, ring wrap
    frame_start();
    for (int ln = 0; ln < 5; ln++) send_line(ln, 8);

    // short middle line masks tap0 beyond its length
    frame_start();
    send_line(0, 8);
    send_line(1, 4);
    send_line(2, 8);

    // overflow: 20 pixels into a 16-pixel line, then a full line
    frame_start();
    send_line(0, 20);
    send_line(1, 16);
    // frame restart clears the flag and hides stale RAM
    frame_start();
    send_line(2, 8);
    send_line(3, 8);
    send_line(4, 8);
    frame_start();
    send_line(5, 8);

    // reset mid-line, pixels ignored until the next LVAL rise
    do_cycle(1, 1, 0, '0);
    for (int c = 0; c < 3; c++) do_cycle(1, 1, 1, DATA_W'(c + 1));
    mid_reset();
    for (int c = 0; c < 3; c++) do_cycle(1, 1, 1, DATA_W'(c + 9));
    do_cycle(1, 0, 0, '0);
    send_line(7, 8);
    send_line(8, 8);
    send_line(9, 8);

    repeat (3) do_cycle(0, 0, 0, '0);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
